stack_round_controller: RTL and testbench
=========================================

Name: stack_round_controller

Overview:
- Per-round sequencer for the block-stacker game.
- Sweeps the current block horizontally and latches it on the player's stop press.
- Computes the overlap with the previously placed block, then trims the block, issues the commit strobes to the block tracker, requests a redraw, and advances the level or ends the game.
- Sits between the debounced buttons, the block tracker and the VGA row drawer.

Parameters:
- SCREEN_W, 320, playfield width in pixels; x range is 0..SCREEN_W-1.
- CELL_W_LOG2, 3, log2 of block cell width in pixels (default 8 px cells).
- INIT_SIZE, 6, block size in cells at level 0 (1..15).
- MAX_LEVEL, 15, number of rows; placing row MAX_LEVEL-1 wins.
- MOVE_DIV, 2500000, clk cycles per one-cell movement step (>=2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start_btn  in  1  debounced level; rising edge starts or restarts a game
- stop_btn  in  1  debounced level; rising edge stops the moving block
- prev_block_start  in  9  left pixel of the last placed block (from tracker)
- prev_block_end  in  9  right pixel, inclusive (from tracker)
- prev_block_size  in  4  size in cells of the last placed block; 0 = none
- draw_ack  in  1  drawer has finished the requested row
- curr_block_start  out  9  current block left pixel
- curr_block_end  out  9  current block right pixel, inclusive
- curr_block_size  out  4  current block size in cells
- stop_true  out  1  one-cycle commit strobe to tracker
- intersect_true  out  1  valid with stop_true; 1 = block landed
- draw_req  out  1  row redraw request
- draw_row  out  5  row index to draw (= level)
- level  out  5  current row, 0-based
- game_over  out  1  sticky until next start
- game_win  out  1  sticky until next start
- busy  out  1  high in every state except IDLE, LOSE and WIN

Behaviour:
- Reset (async, active-high) forces state IDLE and clears every output to 0, including the move timer, direction and edge-detect flops.
- Edge detection: rising edge = input high now and low on the previous clk; one register stage per button.
- Geometry:
  - end = start + (size << CELL_W_LOG2) - 1.
  - start is always a multiple of 2^CELL_W_LOG2.
  - All arithmetic is 10-bit internally; results are truncated to 9 bits only after the range check.
- States:
  - IDLE: wait for a start edge → SPAWN.
  - SPAWN:
    - On entry from IDLE/LOSE/WIN: level = 0, size = INIT_SIZE, clear game_over and game_win.
    - On entry from NEXT: size is taken from the trimmed result.
    - Set start = 0, dir = right, timer = 0. Next cycle → MOVE.
  - MOVE:
    - Timer counts 0..MOVE_DIV-1; at the terminal count it steps one cell.
    - Moving right: if end + cell > SCREEN_W-1, set dir = left and step left instead.
    - Moving left: if start == 0, set dir = right and step right instead.
    - A block as wide as the screen never moves.
    - A stop edge → CHECK on the next cycle. The stop edge has priority over a same-cycle step; the step is dropped.
  - CHECK (1 cycle):
    - If level == 0 or prev_block_size == 0: hit = 1, block unchanged.
    - Otherwise: os = max(starts), oe = min(ends); hit = (os <= oe).
    - On hit, the block is trimmed to start = os, end = oe, size = (oe - os + 1) >> CELL_W_LOG2.
    - Assert stop_true = 1 and intersect_true = hit for exactly this cycle.
    - hit → DRAW; miss → LOSE.
  - DRAW:
    - Assert draw_req with draw_row = level; hold it until a cycle where draw_ack = 1, then → NEXT.
    - draw_ack outside DRAW is ignored.
  - NEXT:
    - If level == MAX_LEVEL-1 → WIN.
    - Otherwise level += 1 → SPAWN.
  - LOSE: game_over = 1. WIN: game_win = 1.
    - Both hold curr_block_* unchanged.
    - A start edge → SPAWN with a fresh game.
- A start edge in MOVE, CHECK, DRAW or NEXT is ignored.
- Reset mid-round (including mid-DRAW): draw_req drops immediately; the tracker is cleared by its own reset.
- Outputs are registered except stop_true and intersect_true, which are a Moore decode of CHECK.

Decomposition:
- Package stack_pkg holds:
  - state enum (IDLE, SPAWN, MOVE, CHECK, DRAW, NEXT, LOSE, WIN)
  - coordinate widths (X_W = 9, SIZE_W = 4, ROW_W = 5)
  - CELL_W_LOG2 default
- One sub-module, block_mover: move timer, direction flop and bounce logic. Interface: enable, load, size in; start out.
- CHECK overlap arithmetic stays inline.

Test Plan:
- Reset then start edge, MOVE_DIV = 4 → after 4 cycles in MOVE, start = 8 and end = 55 (size 6). Reset mid-MOVE → all outputs 0 and state IDLE.
- Level 0 stop with block at start = 40 → stop_true = 1 and intersect_true = 1 for one cycle. Then draw_req = 1 with draw_row = 0, held for 5 cycles until draw_ack; then level = 1 and size stays 6.
- Level 1: prev = 40..87, block stopped at 64..111 → trimmed to 64..87, size 3, intersect_true = 1.
- Level 1: prev = 40..87, block stopped at 88..135 → intersect_true = 0, game_over = 1, busy = 0. A start edge → level = 0, size = 6, game_over = 0.
- Bounce: size 6 reaching start = 272 (end = 319) → next step gives start = 264, dir = left. At start = 0 → next step gives start = 8.
- MAX_LEVEL = 2, two full hits → game_win = 1 after the second draw_ack. Stop edge coincident with a step tick → no step taken and CHECK uses the pre-step position.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and geometry helpers for the block-stacker round controller.
package stack_pkg;

    localparam int X_W             = 9;   // pixel coordinate width
    localparam int SIZE_W          = 4;   // block size in cells
    localparam int ROW_W           = 5;   // row / level index
    localparam int CALC_W          = 10;  // internal geometry width, one bit of headroom
    localparam int CELL_W_LOG2_DEF = 3;   // 8 px cells

    typedef logic [CALC_W-1:0] calc_t;

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        MOVE,
        CHECK,
        DRAW,
        NEXT,
        LOSE,
        WIN
    } state_t;

    // Right-most pixel (inclusive) of a block starting at 'start' that is 'size' cells wide.
    function automatic calc_t block_last(input calc_t start, input logic [SIZE_W-1:0] size,
                                         input int cell_log2);
        return start + (calc_t'(size) << cell_log2) - calc_t'(1);
    endfunction

endpackage

// File: rtl/block_mover.sv
// Horizontal sweep of the current block: cell-step timer, direction flop and
// wall bounce. 'load' places the block at load_start heading right.
module block_mover
    import stack_pkg::*;
#(
    parameter int SCREEN_W    = 320,
    parameter int CELL_W_LOG2 = CELL_W_LOG2_DEF,
    parameter int MOVE_DIV    = 2500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              load,
    input  logic [X_W-1:0]    load_start,
    input  logic [SIZE_W-1:0] size,
    output logic [X_W-1:0]    start,
    output logic [X_W-1:0]    last
);

    localparam int    TIMER_W     = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MOVE_DIV - 1);
    localparam calc_t CELL        = calc_t'(1 << CELL_W_LOG2);
    localparam calc_t SCREEN_LAST = calc_t'(SCREEN_W - 1);
    localparam calc_t ONE         = calc_t'(1);

    logic [TIMER_W-1:0] timer;
    logic               dir_left;
    logic               dir_next;
    logic               tick;
    logic               room_right;
    logic               room_left;
    calc_t              width;
    calc_t              start_w;
    calc_t              end_w;
    calc_t              nxt_start;

    // Next position: keep going while there is room, otherwise reverse; a
    // block with no room on either side stays put.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        dir_next   = dir_left;
        width      = calc_t'(size) << CELL_W_LOG2;
        start_w    = calc_t'(start);
        end_w      = block_last(start_w, size, CELL_W_LOG2);
        nxt_start  = start_w;
        tick       = (timer == TIMER_LAST);
        room_right = (end_w + CELL <= SCREEN_LAST);
        room_left  = (start_w != '0);
        if (!dir_left) begin
            if (room_right) begin
                nxt_start = start_w + CELL;
            end else if (room_left) begin
                dir_next  = 1'b1;
                nxt_start = start_w - CELL;
            end
        end else begin
            if (room_left) begin
                nxt_start = start_w - CELL;
            end else if (room_right) begin
                dir_next  = 1'b0;
                nxt_start = start_w + CELL;
            end
        end
    end

    // Timer, direction and position registers; load wins over a step.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer    <= '0;
            dir_left <= 1'b0;
            start    <= '0;
            last     <= '0;
        end else if (load) begin
            timer    <= '0;
            dir_left <= 1'b0;
            start    <= load_start;
            last     <= X_W'(calc_t'(load_start) + width - ONE);
        end else if (enable) begin
            if (tick) begin
                timer    <= '0;
                dir_left <= dir_next;
                start    <= X_W'(nxt_start);
                last     <= X_W'(nxt_start + width - ONE);
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stack_round_controller.sv
// Per-round sequencer for the block stacker: sweep, latch on stop, overlap
// check and trim, tracker commit strobe, redraw handshake, level advance.
module stack_round_controller
    import stack_pkg::*;
#(
    parameter int SCREEN_W    = 320,
    parameter int CELL_W_LOG2 = CELL_W_LOG2_DEF,
    parameter int INIT_SIZE   = 6,
    parameter int MAX_LEVEL   = 15,
    parameter int MOVE_DIV    = 2500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_btn,
    input  logic              stop_btn,
    input  logic [X_W-1:0]    prev_block_start,
    input  logic [X_W-1:0]    prev_block_end,
    input  logic [SIZE_W-1:0] prev_block_size,
    input  logic              draw_ack,
    output logic [X_W-1:0]    curr_block_start,
    output logic [X_W-1:0]    curr_block_end,
    output logic [SIZE_W-1:0] curr_block_size,
    output logic              stop_true,
    output logic              intersect_true,
    output logic              draw_req,
    output logic [ROW_W-1:0]  draw_row,
    output logic [ROW_W-1:0]  level,
    output logic              game_over,
    output logic              game_win,
    output logic              busy
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MAX_LEVEL - 1);

    state_t              state;
    state_t              state_d;
    logic                start_q;
    logic                stop_q;
    logic                start_edge;
    logic                stop_edge;
    logic                fresh_game;
    logic                mv_enable;
    logic                mv_load;
    logic [X_W-1:0]      mv_load_start;
    logic [SIZE_W-1:0]   mv_size;
    logic                first_row;
    logic                hit;
    calc_t               cs;
    calc_t               ce;
    calc_t               ps;
    calc_t               pe;
    calc_t               os;
    calc_t               oe;
    calc_t               trim_w;
    logic [SIZE_W-1:0]   trim_size;

    block_mover #(
        .SCREEN_W    (SCREEN_W),
        .CELL_W_LOG2 (CELL_W_LOG2),
        .MOVE_DIV    (MOVE_DIV)
    ) u_mover (
        .clk        (clk),
        .reset      (reset),
        .enable     (mv_enable),
        .load       (mv_load),
        .load_start (mv_load_start),
        .size       (mv_size),
        .start      (curr_block_start),
        .last       (curr_block_end)
    );

    // One-stage button history for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            start_q <= start_btn;
            stop_q  <= stop_btn;
        end
    end

    assign start_edge = start_btn & ~start_q;
    assign stop_edge  = stop_btn & ~stop_q;

    // Overlap of the latched block with the last placed one, in 10-bit space.
    always_comb begin
        cs        = calc_t'(curr_block_start);
        ce        = calc_t'(curr_block_end);
        ps        = calc_t'(prev_block_start);
        pe        = calc_t'(prev_block_end);
        os        = (cs > ps) ? cs : ps;
        oe        = (ce < pe) ? ce : pe;
        first_row = (level == '0) || (prev_block_size == '0);
        hit       = first_row || (os <= oe);
        trim_w    = oe - os + calc_t'(1);
        trim_size = SIZE_W'(trim_w >> CELL_W_LOG2);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state decode and mover control.
    always_comb begin
        state_d       = state;
        fresh_game    = 1'b0;
        mv_enable     = 1'b0;
        mv_load       = 1'b0;
        mv_load_start = '0;
        mv_size       = curr_block_size;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    fresh_game = 1'b1;
                    state_d    = SPAWN;
                end
            end
            SPAWN: begin
                mv_load = 1'b1;
                state_d = MOVE;
            end
            MOVE: begin
                // A stop edge freezes the block where it is, dropping any same-cycle step.
                if (stop_edge) begin
                    state_d = CHECK;
                end else begin
                    mv_enable = 1'b1;
                end
            end
            CHECK: begin
                if (hit) begin
                    state_d = DRAW;
                    if (!first_row) begin
                        mv_load       = 1'b1;
                        mv_load_start = os[X_W-1:0];
                        mv_size       = trim_size;
                    end
                end else begin
                    state_d = LOSE;
                end
            end
            DRAW: begin
                if (draw_ack) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                state_d = (level == LAST_ROW) ? WIN : SPAWN;
            end
            LOSE, WIN: begin
                if (start_edge) begin
                    fresh_game = 1'b1;
                    state_d    = SPAWN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered round outputs, derived from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level           <= '0;
            curr_block_size <= '0;
            game_over       <= 1'b0;
            game_win        <= 1'b0;
            draw_req        <= 1'b0;
            draw_row        <= '0;
            busy            <= 1'b0;
        end else begin
            if (fresh_game) begin
                level           <= '0;
                curr_block_size <= SIZE_W'(INIT_SIZE);
                game_over       <= 1'b0;
                game_win        <= 1'b0;
            end
            if (state == CHECK && hit && !first_row) begin
                curr_block_size <= trim_size;
            end
            if (state == NEXT && state_d == SPAWN) begin
                level <= level + 1'b1;
            end
            if (state_d == LOSE) begin
                game_over <= 1'b1;
            end
            if (state_d == WIN) begin
                game_win <= 1'b1;
            end
            if (state_d == DRAW) begin
                draw_row <= level;
            end
            draw_req <= (state_d == DRAW);
            busy     <= !(state_d inside {IDLE, LOSE, WIN});
        end
    end

    // Tracker commit strobe is a pure decode of CHECK.
    assign stop_true      = (state == CHECK);
    assign intersect_true = (state == CHECK) && hit;

endmodule

// File: tb/tb_stack_round_controller.sv
// Scoreboard bench for stack_round_controller: a driver plays games against a
// cell-level reference model and queues the expected round results; a monitor
// compares them whenever the DUT commits a block.
module tb_stack_round_controller;

    localparam int SCREEN_W  = 320;
    localparam int CELL_LOG2 = 3;
    localparam int INIT_SIZE = 6;
    localparam int MAX_LEVEL = 3;
    localparam int MOVE_DIV  = 4;
    localparam int CELL      = 1 << CELL_LOG2;
    localparam int CELLS     = SCREEN_W / CELL;

    logic       clk;
    logic       reset;
    logic       start_btn;
    logic       stop_btn;
    logic [8:0] prev_block_start;
    logic [8:0] prev_block_end;
    logic [3:0] prev_block_size;
    logic       draw_ack;
    logic [8:0] curr_block_start;
    logic [8:0] curr_block_end;
    logic [3:0] curr_block_size;
    logic       stop_true;
    logic       intersect_true;
    logic       draw_req;
    logic [4:0] draw_row;
    logic [4:0] level;
    logic       game_over;
    logic       game_win;
    logic       busy;

    stack_round_controller #(
        .SCREEN_W    (SCREEN_W),
        .CELL_W_LOG2 (CELL_LOG2),
        .INIT_SIZE   (INIT_SIZE),
        .MAX_LEVEL   (MAX_LEVEL),
        .MOVE_DIV    (MOVE_DIV)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start_btn        (start_btn),
        .stop_btn         (stop_btn),
        .prev_block_start (prev_block_start),
        .prev_block_end   (prev_block_end),
        .prev_block_size  (prev_block_size),
        .draw_ack         (draw_ack),
        .curr_block_start (curr_block_start),
        .curr_block_end   (curr_block_end),
        .curr_block_size  (curr_block_size),
        .stop_true        (stop_true),
        .intersect_true   (intersect_true),
        .draw_req         (draw_req),
        .draw_row         (draw_row),
        .level            (level),
        .game_over        (game_over),
        .game_win         (game_win),
        .busy             (busy)
    );

    typedef struct {
        int row;
        int pre_s;
        int pre_e;
        int pre_sz;
        int hit;
        int t_s;
        int t_e;
        int t_sz;
        int win;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model of the game as seen by the player.
    int lvl;
    int sz;
    int ps;
    int pe;
    int psz;
    int lead;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " start"}, curr_block_start, 0);
        check({tag, " end"}, curr_block_end, 0);
        check({tag, " size"}, curr_block_size, 0);
        check({tag, " stop_true"}, stop_true, 0);
        check({tag, " intersect"}, intersect_true, 0);
        check({tag, " draw_req"}, draw_req, 0);
        check({tag, " draw_row"}, draw_row, 0);
        check({tag, " level"}, level, 0);
        check({tag, " game_over"}, game_over, 0);
        check({tag, " game_win"}, game_win, 0);
        check({tag, " busy"}, busy, 0);
    endtask

    task automatic drive_prev();
        prev_block_start = 9'(ps);
        prev_block_end   = 9'(pe);
        prev_block_size  = 4'(psz);
    endtask

    // Left pixel after s cell steps from 0: a triangle wave over 0..M cells.
    function automatic int pos_after(input int s, input int size);
        int m;
        int p;
        m = CELLS - size;
        if (m <= 0) return 0;
        p = s % (2 * m);
        if (p > m) p = 2 * m - p;
        return p * CELL;
    endfunction

    // Step count that puts the block at a chosen hit/miss position.
    function automatic int aim(input bit want_hit);
        int m;
        int pc;
        int lo;
        int hi;
        int p;
        m = CELLS - sz;
        if (lvl == 0 || psz == 0) begin
            p = int'($urandom_range(m, 0));
        end else begin
            pc = ps / CELL;
            lo = (pc - sz + 1 > 0) ? pc - sz + 1 : 0;
            hi = (pc + psz - 1 < m) ? pc + psz - 1 : m;
            if (want_hit)        p = int'($urandom_range(hi, lo));
            else if (hi + 1 <= m) p = int'($urandom_range(m, hi + 1));
            else if (lo >= 1)    p = int'($urandom_range(lo - 1, 0));
            else                 p = int'($urandom_range(hi, lo));
        end
        if (($urandom % 2) == 1 && p > 0) return 2 * m - p;
        return p;
    endfunction

    task automatic begin_game();
        @(negedge clk);
        start_btn = 1'b1;
        lvl  = 0;
        sz   = INIT_SIZE;
        lead = 1;
        psz  = int'($urandom_range(6, 0));
        ps   = CELL * int'($urandom_range(CELLS - 6, 0));
        pe   = (psz > 0) ? ps + psz * CELL - 1 : 0;
        drive_prev();
    endtask

    // Let the block make s steps, stop it, then serve the redraw handshake.
    task automatic play_round(input int s, input bit coinc, input int hold, output bit ended);
        int   c;
        int   wait_n;
        bit   seen;
        exp_t e;
        c = coinc ? (s + 1) * MOVE_DIV : s * MOVE_DIV + 1 + int'($urandom_range(MOVE_DIV - 1, 0));
        wait_n = lead + c;
        for (int i = 0; i < wait_n; i++) begin
            @(negedge clk);
            start_btn = 1'b0;
            draw_ack  = 1'b0;
            if (c >= 4 && i == lead + 1) begin
                start_btn = 1'b1;   // must be ignored while moving
                draw_ack  = 1'b1;   // must be ignored outside DRAW
            end
        end
        e.row    = lvl;
        e.pre_sz = sz;
        e.pre_s  = pos_after(s, sz);
        e.pre_e  = e.pre_s + sz * CELL - 1;
        if (lvl == 0 || psz == 0) begin
            e.hit = 1;
            e.t_s = e.pre_s;
            e.t_e = e.pre_e;
        end else begin
            e.t_s = (e.pre_s > ps) ? e.pre_s : ps;
            e.t_e = (e.pre_e < pe) ? e.pre_e : pe;
            e.hit = (e.t_s <= e.t_e) ? 1 : 0;
        end
        e.t_sz = e.hit ? (e.t_e - e.t_s + 1) / CELL : 0;
        e.win  = (e.hit == 1 && lvl == MAX_LEVEL - 1) ? 1 : 0;
        exp_q.push_back(e);
        stop_btn = 1'b1;
        @(negedge clk);
        stop_btn = 1'b0;
        ended = 1'b0;
        if (e.hit == 1) begin
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk);
                if (draw_req === 1'b1) seen = 1'b1;
            end
            check("draw_req seen", int'(seen), 1);
            repeat (hold) @(negedge clk);
            draw_ack = 1'b1;
            lead = 2;
            ps  = e.t_s;
            pe  = e.t_e;
            psz = e.t_sz;
            sz  = e.t_sz;
            drive_prev();
            if (e.win == 1) begin
                ended = 1'b1;
                @(negedge clk);
                draw_ack = 1'b0;
                repeat (3) @(negedge clk);
            end else begin
                lvl++;
            end
        end else begin
            ended = 1'b1;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic random_game();
        bit ended;
        begin_game();
        ended = 1'b0;
        while (!ended) begin
            play_round(aim(($urandom % 4) != 0), ($urandom % 3) == 0,
                       int'($urandom_range(6, 0)), ended);
        end
    endtask

    // Monitor: every commit strobe is matched against the oldest expectation.
    initial begin : monitor
        exp_t e;
        int   n;
        forever begin
            @(negedge clk);
            #1;
            if (stop_true === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected stop_true", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("intersect_true", int'(intersect_true), e.hit);
                    check("stop start", curr_block_start, e.pre_s);
                    check("stop end", curr_block_end, e.pre_e);
                    check("stop size", curr_block_size, e.pre_sz);
                    @(negedge clk);
                    #1;
                    check("stop_true one cycle", int'(stop_true), 0);
                    if (e.hit == 1) begin
                        check("draw_req", int'(draw_req), 1);
                        check("draw_row", draw_row, e.row);
                        check("trim start", curr_block_start, e.t_s);
                        check("trim end", curr_block_end, e.t_e);
                        check("trim size", curr_block_size, e.t_sz);
                        check("busy in draw", int'(busy), 1);
                        n = 0;
                        while (draw_ack !== 1'b1 && n < 50) begin
                            @(negedge clk);
                            #1;
                            n++;
                            check("draw_req held", int'(draw_req), 1);
                        end
                        check("draw_ack arrived", int'(draw_ack === 1'b1), 1);
                        @(negedge clk);
                        #1;
                        check("draw_req dropped", int'(draw_req), 0);
                        @(negedge clk);
                        #1;
                        check("size after round", curr_block_size, e.t_sz);
                        if (e.win == 1) begin
                            check("game_win", int'(game_win), 1);
                            check("busy after win", int'(busy), 0);
                            check("level at win", level, e.row);
                        end else begin
                            check("level advanced", level, e.row + 1);
                            check("game_win clear", int'(game_win), 0);
                            check("busy next round", int'(busy), 1);
                        end
                    end else begin
                        @(negedge clk);
                        #1;
                        check("game_over", int'(game_over), 1);
                        check("busy after loss", int'(busy), 0);
                        check("no draw on miss", int'(draw_req), 0);
                        check("held start on loss", curr_block_start, e.pre_s);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        bit ended;
        reset            = 1'b0;
        start_btn        = 1'b0;
        stop_btn         = 1'b0;
        draw_ack         = 1'b0;
        prev_block_start = '0;
        prev_block_end   = '0;
        prev_block_size  = '0;
        lvl = 0; sz = INIT_SIZE; ps = 0; pe = 0; psz = 0; lead = 1;
        #2 reset = 1'b1;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // First sweep: one cell step after MOVE_DIV cycles, then reset mid-move.
        begin_game();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start_btn = 1'b0;
            if (i == 4) check("move before tick", curr_block_start, 0);
        end
        check("first step start", curr_block_start, 8);
        check("first step end", curr_block_end, 55);
        check("first step size", curr_block_size, 6);
        check("busy in move", int'(busy), 1);
        reset = 1'b1;
        #1 check_all_zero("mid-move reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Level 0 at 40, level 1 trimmed to 64..87, level 2 wins.
        begin_game();
        play_round(5, 1'b0, 5, ended);
        play_round(8, 1'b0, 2, ended);
        play_round(aim(1'b1), 1'b0, 1, ended);

        // Level 1 miss at 88..135 against 40..87, then restart clears game_over.
        begin_game();
        play_round(5, 1'b0, 0, ended);
        play_round(11, 1'b0, 0, ended);
        begin_game();
        repeat (2) @(negedge clk);
        start_btn = 1'b0;
        check("restart level", level, 0);
        check("restart size", curr_block_size, INIT_SIZE);
        check("restart game_over", int'(game_over), 0);
        lead = -1;   // two negedges of this game already elapsed
        play_round(35, 1'b0, 3, ended);        // bounced off the right wall: 264
        while (!ended) play_round(aim(1'b1), 1'b1, 1, ended);

        // Bounce off the left wall, and stops coincident with a step tick.
        begin_game();
        play_round(69, 1'b1, 0, ended);        // back at 8 after touching 0
        while (!ended) play_round(aim(($urandom % 2) == 0), 1'b1, 2, ended);

        for (int g = 0; g < 8; g++) random_game();

        repeat (5) @(negedge clk);
        check("pending expectations", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
